// File: rtl/shift_unit.sv
// Purpose  : multi-cycle SLL/SRL/SRA/ROR unit on a WIDTH-bit operand, up to STEP bits per clock.
// Latency  : 1 edge for shamt 0, otherwise 1 + ceil(shamt/STEP) edges from accept to out_valid.
// Backpres : in_ready only in IDLE; DONE holds result/carry/zero stable until out_ready.
//
// Ports:
//   Clock, Reset_n            - rising-edge clock, async active-low reset
//   in_valid/in_ready         - operand handshake (in_data, in_shamt, in_mode)
//   out_valid/out_ready       - result handshake (out_data, out_carry, out_zero)
//   in_mode                   - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//
// Build option: define SHIFT_UNIT_ROTATE_EN to build the rotate datapath.
// Without it, mode 11 executes exactly as SRL.
module shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRA = 2'b10;
`ifdef SHIFT_UNIT_ROTATE_EN
    localparam logic [1:0] M_ROR = 2'b11;
`endif

    // remaining never exceeds WIDTH-1, so a per-cycle step of WIDTH behaves
    // exactly like WIDTH-1 and the clamped value fits in SW bits.
    localparam int           STEP_C = (STEP < WIDTH) ? STEP : WIDTH - 1;
    localparam logic [SW-1:0] STEP_K = SW'(STEP_C);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       mode_r;
    logic             sign_r;
    logic [SW-1:0]    remaining;
    logic             carry_r;
    logic             zero_r;

    logic [SW-1:0]    k;
    logic [WIDTH:0]   ext_l;
    logic [WIDTH:0]   ext_r;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_carry;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_data  = data_r;
    assign out_carry = carry_r;
    assign out_zero  = zero_r;

    // One shift step of k bits. The extra bit on each side of the extended
    // vectors catches the last bit shifted out, which becomes the carry.
    always_comb begin
        k         = (remaining > STEP_K) ? STEP_K : remaining;
        ext_l     = {1'b0, data_r} << k;
        ext_r     = {data_r, 1'b0} >> k;
        fill      = ~({WIDTH{1'b1}} >> k);
        nxt_data  = ext_r[WIDTH:1];
        nxt_carry = ext_r[0];
        case (mode_r)
            M_SLL: begin
                nxt_data  = ext_l[WIDTH-1:0];
                nxt_carry = ext_l[WIDTH];
            end
            M_SRA: begin
                // Fill from the sign captured at accept, not the working value.
                nxt_data  = ext_r[WIDTH:1] | (sign_r ? fill : '0);
                nxt_carry = ext_r[0];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            M_ROR: begin
                // Low k bits wrap to the top; the last bit moved lands in the
                // MSB, so it matches the bit that falls out of ext_r.
                nxt_data  = ext_r[WIDTH:1] | (data_r << (WIDTH - int'(k)));
                nxt_carry = ext_r[0];
            end
`endif
            default: begin
                nxt_data  = ext_r[WIDTH:1];
                nxt_carry = ext_r[0];
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            data_r    <= '0;
            mode_r    <= '0;
            sign_r    <= 1'b0;
            remaining <= '0;
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data_r    <= in_data;
                        mode_r    <= in_mode;
                        sign_r    <= in_data[WIDTH-1];
                        remaining <= in_shamt;
                        carry_r   <= 1'b0;
                        zero_r    <= (in_data == '0);
                        state     <= (in_shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_r    <= nxt_data;
                    carry_r   <= nxt_carry;
                    zero_r    <= (nxt_data == '0);
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Purpose  : randomized + directed check of shift_unit (WIDTH=16, STEP=4) against a reference model.
// Latency  : checks accept-to-out_valid edge count for every operation.
// Backpres : holds out_ready low for random spans with in_valid toggling and checks stability.
module tb_shift_unit;

    localparam int W    = 16;
    localparam int STEP = 4;

    logic          Clock;
    logic          Reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_shamt;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    int vectors;
    int miscompares;

    shift_unit #(.WIDTH(W), .STEP(STEP)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the whole shift amount.
    function automatic logic [W-1:0] ref_data(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic signed [W-1:0] sa;
        sa = a;
        case (m)
            2'b00: return a << s;
            2'b10: return sa >>> s;
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11: return (s == 0) ? a : ((a >> s) | (a << (W - s)));
`endif
            default: return a >> s;
        endcase
    endfunction

    function automatic logic ref_carry(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic [W-1:0] r;
        if (s == 0) return 1'b0;
        r = ref_data(a, s, m);
`ifdef SHIFT_UNIT_ROTATE_EN
        if (m == 2'b11) return r[W-1];
`endif
        if (m == 2'b00) return a[W-s];
        return a[s-1];
    endfunction

    function automatic int ref_latency(input int s);
        return (s == 0) ? 1 : 1 + (s + STEP - 1) / STEP;
    endfunction

    // Issue one op, check latency and result, hold it for `hold` cycles of
    // backpressure with junk on the input side, then hand it off.
    task automatic do_op(input logic [W-1:0] a, input int s, input logic [1:0] m, input int hold);
        logic [W-1:0] exp_d;
        logic         exp_c;
        int           lat;
        exp_d = ref_data(a, s, m);
        exp_c = ref_carry(a, s, m);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = a;
        in_shamt = 4'(s);
        in_mode  = m;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_shamt = 4'($urandom);
        in_mode  = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge Clock); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_latency(s)));
        check("data", 32'(out_data), 32'(exp_d));
        check("carry", 32'(out_carry), 32'(exp_c));
        check("zero", 32'(out_zero), 32'(exp_d == '0));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_shamt = 4'($urandom);
            @(posedge Clock); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_data", 32'(out_data), 32'(exp_d));
            check("hold_carry", 32'(out_carry), 32'(exp_c));
            check("hold_zero", 32'(out_zero), 32'(exp_d == '0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("handoff_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_carry"}, 32'(out_carry), 32'd0);
        check({tag, "_zero"}, 32'(out_zero), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_shamt    = '0;
        in_mode     = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_reset_values("reset");
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Directed cases.
        do_op(16'h8001, 4, 2'b10, 0);   // SRA -> 0xF800, carry 0
        do_op(16'h0F0F, 5, 2'b00, 0);   // SLL two steps -> 0xE1E0, carry 1
        do_op(16'h0000, 0, 2'b01, 0);   // shamt 0, zero result
        do_op(16'h0001, 1, 2'b11, 0);   // rotate or SRL depending on build
        do_op(16'hA5C3, 15, 2'b10, 0);  // worst-case latency
        do_op(16'h8000, 15, 2'b01, 0);
        do_op(16'h1234, 7, 2'b00, 5);   // backpressure with in_valid asserted
        do_op(16'hFFFF, 0, 2'b11, 1);

        // Reset abort in the middle of a long SHIFT.
        in_valid = 1'b1;
        in_data  = 16'hC001;
        in_shamt = 4'd15;
        in_mode  = 2'b10;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        @(posedge Clock); #1;
        check("abort_busy", 32'(in_ready), 32'd0);
        Reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        do_op(16'hC001, 15, 2'b10, 0);

        // Randomized operations.
        for (int n = 0; n < 300; n++) begin
            do_op(16'($urandom), int'($urandom_range(0, W - 1)), 2'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
